// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and SR/Cause field positions shared
// by the interrupt controller and its timer.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_t;

   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 8;
   localparam int SR_IM_HI     = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   // A faulting delay-slot instruction restarts at its branch.
   function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
      logic [31:0] base;
      base = {pc[31:2], 2'b00};
      return bd ? base - 32'd4 : base;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, sticky timer_ip on Compare match.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_ip
);

   logic [31:0] count_nxt;

   assign count_nxt = count_we ? wdata : count + 32'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         compare  <= '0;
         timer_ip <= 1'b0;
      end else begin
         count <= count_nxt;
         // Writing Compare acknowledges the timer interrupt.
         if (compare_we) begin
            compare  <= wdata;
            timer_ip <= 1'b0;
         end else if (count_nxt == compare) begin
            timer_ip <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the MEM stage: SR/Cause/EPC,
// PRId, optional Count/Compare timer and the flush/redirect request.
module cp0_irq_ctrl
   import cp0_pkg::*;
#(
   parameter int          N_HWINT      = 6,
   parameter int          ENABLE_TIMER = 1,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
   parameter logic [31:0] PRID         = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [4:0]         addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   input  logic [31:0]        vpc,
   input  logic               bd_in,
   input  logic [4:0]         exc_code_in,
   input  logic [N_HWINT-1:0] hw_int,
   input  logic               exl_clr,
   output logic               req,
   output logic [31:0]        epc_out,
   output logic [31:0]        vec_addr,
   output logic [31:0]        macro_pc
);

   logic [7:0]  im;
   logic        exl, ie, bd;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] count, compare;
   logic        timer_ip;
   logic [5:0]  ip;
   logic        int_req, exc_req, wr_en;

   always_comb begin
      ip             = '0;
      ip[N_HWINT-1:0] = hw_int;
      ip[5]          = ip[5] | timer_ip;
   end

   assign int_req = (|(ip & im[7:2])) & ie & ~exl;
   assign exc_req = (exc_code_in != 5'd0) & ~exl;
   assign req     = int_req | exc_req;
   // A taken exception squashes the mtc0 committing in the same cycle.
   assign wr_en   = we & ~req;

   assign epc_out  = epc;
   assign vec_addr = EXC_VECTOR;
   assign macro_pc = vpc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
      end else if (req) begin
         exl      <= 1'b1;
         bd       <= bd_in;
         exc_code <= int_req ? EXC_INT : exc_code_in;
         epc      <= epc_calc(vpc, bd_in);
      end else begin
         if (wr_en && addr == REG_SR) begin
            im  <= wdata[SR_IM_HI:SR_IM_LO];
            exl <= wdata[SR_EXL];
            ie  <= wdata[SR_IE];
         end
         if (wr_en && addr == REG_EPC)
            epc <= wdata;
         if (exl_clr)
            exl <= 1'b0;
      end
   end

   generate
      if (ENABLE_TIMER != 0) begin : g_timer
         cp0_timer u_timer (
            .clk       (clk),
            .reset     (reset),
            .count_we  (wr_en && addr == REG_COUNT),
            .compare_we(wr_en && addr == REG_COMPARE),
            .wdata     (wdata),
            .count     (count),
            .compare   (compare),
            .timer_ip  (timer_ip)
         );
      end else begin : g_no_timer
         assign count    = '0;
         assign compare  = '0;
         assign timer_ip = 1'b0;
      end
   endgenerate

   always_comb begin
      rdata = '0;
      case (addr)
         REG_SR:      rdata = {16'b0, im, 6'b0, exl, ie};
         REG_CAUSE:   rdata = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
         REG_EPC:     rdata = epc;
         REG_PRID:    rdata = PRID;
         REG_COUNT:   rdata = count;
         REG_COMPARE: rdata = compare;
         default:     rdata = '0;
      endcase
   end

endmodule
